// File: rtl/modinv_fermat_pkg.sv
// -----------------------------------------------------------------------------
// modinv_fermat_pkg
// Shared constants and types for the Fermat modular inverter over Z_q.
//   W, Q, EXP, MUL_LAT  : coefficient width, modulus, exponent Q-2, datapath depth
//   NUM_OPS             : squarings plus multiplies in one exponentiation
//   BARRETT_M/SHIFT     : Barrett constant floor(2^36 / Q) and its shift
//   state_t             : inverter FSM state encoding
// -----------------------------------------------------------------------------
package modinv_fermat_pkg;

    localparam int unsigned  W       = 12;
    localparam int unsigned  Q       = 3329;
    localparam logic [W-1:0] EXP     = 12'b1100_1111_1111;
    localparam int unsigned  MUL_LAT = 1;
    localparam int unsigned  NUM_OPS = 20;

    // 2^36 / 3329 = 20642678 rem 1674. With a 24-bit product the quotient
    // estimate is at most one short, so a single final subtract suffices.
    localparam logic [24:0]  BARRETT_M     = 25'd20642678;
    localparam int unsigned  BARRETT_SHIFT = 36;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQR  = 3'd1,
        ST_MUL  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/modinv_fermat_modmulred_q.sv
// -----------------------------------------------------------------------------
// modmulred_q
// MUL_LAT-stage pipelined X*Y mod Q datapath (Barrett reduction).
//   clk, rst_n : clock, synchronous active-low reset
//   x, y       : operands, 0..4095 (need not be reduced)
//   r          : (x*y) mod Q, 0..Q-1, valid MUL_LAT cycles after x/y
// -----------------------------------------------------------------------------
module modmulred_q
    import modinv_fermat_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] r
);

    logic [23:0]  prod;
    logic [12:0]  qhat;
    logic [12:0]  rem;
    logic [W-1:0] red;
    logic [W-1:0] pipe_d [MUL_LAT];
    logic [W-1:0] pipe_q [MUL_LAT];

    // Barrett: qhat undershoots by at most one, so rem < 2Q < 2^13 and the
    // remainder can be formed in 13-bit modular arithmetic.
    always_comb begin
        prod = 24'(x) * 24'(y);
        qhat = 13'((49'(prod) * 49'(BARRETT_M)) >> BARRETT_SHIFT);
        rem  = prod[12:0] - 13'(qhat * 13'(Q));
        red  = (rem >= 13'(Q)) ? 12'(rem - 13'(Q)) : rem[W-1:0];
    end

    // Result delay line; only the reduced value is staged.
    always_comb begin
        pipe_d[0] = red;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign r = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/modinv_fermat.sv
// -----------------------------------------------------------------------------
// modinv_fermat
// Sequential modular inverter: out_r = in_a^(Q-2) mod Q by left-to-right
// square-and-multiply on a single modmulred_q datapath.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake, in_a (0..4095, taken mod Q)
//   out_valid/out_ready  : result handshake, out_r (0..Q-1) held until taken
//   busy                 : exponentiation or result pending
//   out_err              : only with MODINV_ZERO_ERR_EN; flags in_a mod Q == 0
// Optional feature macro: MODINV_ZERO_ERR_EN (zero operand short-cut + out_err).
// -----------------------------------------------------------------------------
module modinv_fermat
    import modinv_fermat_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic         busy
`ifdef MODINV_ZERO_ERR_EN
    ,
    output logic         out_err
`endif
);

    state_t       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] opnd_q, opnd_d;
    logic [3:0]   k_q, k_d;
    logic [1:0]   wait_cnt_q, wait_cnt_d;
    logic         pend_mul_q, pend_mul_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_r_q, out_r_d;
    logic         busy_q, busy_d;
`ifdef MODINV_ZERO_ERR_EN
    logic         zero_q, zero_d;
    logic         out_err_q, out_err_d;
`endif

    logic [W-1:0] mul_y;
    logic [W-1:0] mul_r;

    // The datapath always sees acc on x; y switches to the original operand
    // only during a multiply issue cycle.
    assign mul_y = (state_q == ST_MUL) ? opnd_q : acc_q;

    modmulred_q u_modmulred_q (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (acc_q),
        .y     (mul_y),
        .r     (mul_r)
    );

    // Next-state logic. The exponent MSB is consumed by loading acc=in_a,
    // so scanning starts at bit W-2.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        k_d         = k_q;
        wait_cnt_d  = wait_cnt_q;
        pend_mul_d  = pend_mul_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        busy_d      = busy_q;
`ifdef MODINV_ZERO_ERR_EN
        zero_d      = zero_q;
        out_err_d   = out_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d      = in_a;
                    opnd_d     = in_a;
                    k_d        = 4'(W - 2);
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SQR;
`ifdef MODINV_ZERO_ERR_EN
                    // 0 and Q are the only multiples of Q below 4096.
                    zero_d     = (in_a == '0) || (in_a == W'(Q));
`endif
                end
            end
            ST_SQR: begin
`ifdef MODINV_ZERO_ERR_EN
                if (zero_q) begin
                    out_valid_d = 1'b1;
                    out_r_d     = '0;
                    out_err_d   = 1'b1;
                    state_d     = ST_DONE;
                end else
`endif
                begin
                    pend_mul_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_MUL: begin
                pend_mul_d = 1'b1;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 2'(MUL_LAT - 1)) begin
                    acc_d = mul_r;
                    if (!pend_mul_q && EXP[k_q]) begin
                        state_d = ST_MUL;
                    end else if (k_q == '0) begin
                        out_valid_d = 1'b1;
                        out_r_d     = mul_r;
`ifdef MODINV_ZERO_ERR_EN
                        out_err_d   = 1'b0;
`endif
                        state_d     = ST_DONE;
                    end else begin
                        k_d     = k_q - 4'd1;
                        state_d = ST_SQR;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
`ifdef MODINV_ZERO_ERR_EN
                    out_err_d   = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any computation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            opnd_q      <= '0;
            k_q         <= '0;
            wait_cnt_q  <= '0;
            pend_mul_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            busy_q      <= 1'b0;
`ifdef MODINV_ZERO_ERR_EN
            zero_q      <= 1'b0;
            out_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            k_q         <= k_d;
            wait_cnt_q  <= wait_cnt_d;
            pend_mul_q  <= pend_mul_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            busy_q      <= busy_d;
`ifdef MODINV_ZERO_ERR_EN
            zero_q      <= zero_d;
            out_err_q   <= out_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign busy      = busy_q;
`ifdef MODINV_ZERO_ERR_EN
    assign out_err   = out_err_q;
`endif

endmodule

// File: tb/tb_modinv_fermat.sv
// -----------------------------------------------------------------------------
// tb_modinv_fermat
// Directed bench for modinv_fermat: known inverses, latency, back-pressure,
// mid-operation reset, zero operand and a random sample of operands.
// -----------------------------------------------------------------------------
module tb_modinv_fermat;
    import modinv_fermat_pkg::*;

    localparam int NOMINAL_LAT = int'(NUM_OPS * (MUL_LAT + 1) + 1);
    localparam int QI          = int'(Q);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_r;
    logic         busy;
`ifdef MODINV_ZERO_ERR_EN
    logic         out_err;
`endif

    int assertCount = 0;
    int failCount   = 0;
    int lastErr     = 0;

    always #5 clk = ~clk;

    modinv_fermat dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
`ifdef MODINV_ZERO_ERR_EN
        ,
        .out_err   (out_err)
`endif
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Send one operand, wait for its result, then take it after holdCycles.
    // latency counts cycles from the accept cycle to the first out_valid cycle.
    task automatic applyStimulus(input int a, input int holdCycles, output int result, output int latency);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("inReadyWait", int'(in_ready), 1);
        in_a     = 12'(a);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        latency  = 1;
        while (!out_valid && latency < 200) begin
            @(posedge clk); #1;
            latency++;
        end
        checkOutput("outValidWait", int'(out_valid), 1);
        result = int'(out_r);
`ifdef MODINV_ZERO_ERR_EN
        lastErr = int'(out_err);
`endif
        repeat (holdCycles) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dirIn  [7] = '{1, 2, 3, 3328, 3330, 4095, 5};
        int dirExp [7] = '{1, 1665, 1110, 3328, 1, 2525, 666};
        int res, lat, held, cyc, sawValid, a, hold;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstInReady", int'(in_ready), 1);
        checkOutput("rstOutValid", int'(out_valid), 0);
        checkOutput("rstOutR", int'(out_r), 0);
        checkOutput("rstBusy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed inverses with hand-computed results
        for (int i = 0; i < 7; i++) begin
            applyStimulus(dirIn[i], 0, res, lat);
            checkOutput($sformatf("inv(%0d)", dirIn[i]), res, dirExp[i]);
            checkOutput($sformatf("lat(%0d)", dirIn[i]), lat, NOMINAL_LAT);
`ifdef MODINV_ZERO_ERR_EN
            checkOutput($sformatf("err(%0d)", dirIn[i]), lastErr, 0);
`endif
        end
        checkOutput("inv4095Prod", (res * 0 + ((2525 * 766) % QI)), 1);

        // Back-pressure: hold the result for 10 cycles while pulsing in_valid
        in_a     = 12'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bpLatency", lat, NOMINAL_LAT);
        held = int'(out_r);
        checkOutput("bpValue", held, 666);
        for (int j = 0; j < 10; j++) begin
            in_valid = (j % 2 == 0);
            in_a     = 12'(j + 100);
            @(posedge clk); #1;
            checkOutput("bpStable", int'(out_r), held);
            checkOutput("bpInReady", int'(in_ready), 0);
            checkOutput("bpOutValid", int'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bpReleaseInReady", int'(in_ready), 1);
        checkOutput("bpReleaseOutValid", int'(out_valid), 0);
        checkOutput("bpReleaseBusy", int'(busy), 0);

        // Reset in the middle of a computation aborts it
        in_a     = 12'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("midBusy", int'(busy), 1);
        checkOutput("midInReady", int'(in_ready), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("abortInReady", int'(in_ready), 1);
        checkOutput("abortOutR", int'(out_r), 0);
        checkOutput("abortBusy", int'(busy), 0);
        sawValid = 0;
        for (int j = 0; j < 60; j++) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1;
        end
        checkOutput("abortNoResult", sawValid, 0);
        applyStimulus(2, 0, res, lat);
        checkOutput("afterAbortInv", res, 1665);
        checkOutput("afterAbortLat", lat, NOMINAL_LAT);

        // Zero operand (0 and Q)
        applyStimulus(0, 0, res, lat);
        checkOutput("zeroResult", res, 0);
`ifdef MODINV_ZERO_ERR_EN
        checkOutput("zeroLat", lat, 2);
        checkOutput("zeroErr", lastErr, 1);
`else
        checkOutput("zeroLat", lat, NOMINAL_LAT);
`endif
        applyStimulus(QI, 0, res, lat);
        checkOutput("qResult", res, 0);
`ifdef MODINV_ZERO_ERR_EN
        checkOutput("qErr", lastErr, 1);
`endif

        // Random sample of nonzero operands with random back-pressure
        for (int n = 0; n < 250; n++) begin
            a    = int'($urandom_range(1, QI - 1));
            hold = int'($urandom_range(0, 3));
            applyStimulus(a, hold, res, lat);
            checkOutput($sformatf("sweepInv(%0d)", a), (res * a) % QI, 1);
            checkOutput($sformatf("sweepRange(%0d)", a), int'(res < QI), 1);
            checkOutput($sformatf("sweepLat(%0d)", a), lat, NOMINAL_LAT);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
